iterative_alu: RTL and testbench

//  Execute stage of KGP-RISC; sits directly upstream of register_file and drives its writeData/writeEnable.

---
 rtl/kgp_risc_pkg.sv | 33 +++
 rtl/iterative_alu_if.sv | 36 +++
 rtl/alu_comb.sv | 31 +++
 rtl/iterative_alu.sv | 182 ++++++++++++++++++
 tb/tb_iterative_alu.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg
// Shared definitions for the KGP-RISC execute stage.
//   - alu_op_e    : aluOp encodings (ALU_ADD .. ALU_SHRA, ALU_ILLEGAL)
//   - alu_state_e : iterative_alu FSM state encoding
//   - isShiftOp   : true for the three variable-shift opcodes
package kgp_risc_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_SHAMT_W = 5;
    localparam int RD_W        = 5;

    typedef enum logic [2:0] {
        ALU_ADD     = 3'b000,
        ALU_COMP    = 3'b001,
        ALU_AND     = 3'b010,
        ALU_XOR     = 3'b011,
        ALU_SHLL    = 3'b100,
        ALU_SHRL    = 3'b101,
        ALU_SHRA    = 3'b110,
        ALU_ILLEGAL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } alu_state_e;

    function automatic logic isShiftOp(input logic [2:0] op);
        return (op == ALU_SHLL) || (op == ALU_SHRL) || (op == ALU_SHRA);
    endfunction

endpackage

// File: rtl/iterative_alu_if.sv
// iterative_alu_if
// Request/response bundle between the decode stage and iterative_alu.
//   master : drives start, aluOp, opA, opB, rdIn; observes the results
//   slave  : the ALU itself
//   Request  : start, aluOp[2:0], opA/opB[WIDTH-1:0], rdIn[4:0]
//   Response : busy, done, regWrite, result[WIDTH-1:0], rdOut[4:0],
//              carry, zero, sign, illegalOp
interface iterative_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       aluOp;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [4:0]       rdIn;

    logic             busy;
    logic             done;
    logic             regWrite;
    logic [WIDTH-1:0] result;
    logic [4:0]       rdOut;
    logic             carry;
    logic             zero;
    logic             sign;
    logic             illegalOp;

    modport master (
        output start, aluOp, opA, opB, rdIn,
        input  busy, done, regWrite, result, rdOut, carry, zero, sign, illegalOp
    );

    modport slave (
        input  start, aluOp, opA, opB, rdIn,
        output busy, done, regWrite, result, rdOut, carry, zero, sign, illegalOp
    );
endinterface

// File: rtl/alu_comb.sv
// alu_comb
// Single-cycle datapath for ADD, COMP, AND and XOR.
//   aluOp[2:0]     in  : operation select
//   a, b[WIDTH-1:0] in : operands (a is ignored by COMP)
//   out[WIDTH:0]   out : {carry, value}; carry is only ever set by ADD
// Shift and illegal opcodes return zero; the caller handles those.
module alu_comb
    import kgp_risc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       aluOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   out
);

    // COMP is two's-complement negation; its carry is defined as 0, so the
    // increment is done at WIDTH bits and the top bit forced low.
    always_comb begin
        out = '0;
        case (alu_op_e'(aluOp))
            ALU_ADD:  out = {1'b0, a} + {1'b0, b};
            ALU_COMP: out = {1'b0, (~b) + WIDTH'(1)};
            ALU_AND:  out = {1'b0, a & b};
            ALU_XOR:  out = {1'b0, a ^ b};
            default:  out = '0;
        endcase
    end

endmodule

// File: rtl/iterative_alu.sv
// iterative_alu
// KGP-RISC execute stage. Latches a request on start (sampled only in IDLE),
// computes ADD/COMP/AND/XOR in one cycle and variable shifts one bit per
// cycle, then presents a one-cycle done/regWrite pulse with the result,
// destination address and flags. Result, rdOut and flags change only on
// entry to DONE and hold otherwise.
//   clk  in : rising-edge clock
//   rst  in : asynchronous active-high reset; aborts any operation in flight
//   bus     : iterative_alu_if.slave (request and response signals)
module iterative_alu
    import kgp_risc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    iterative_alu_if.slave        bus
);

    alu_state_e         state;
    alu_op_e            opReg;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] count;
    logic [RD_W-1:0]    rdReg;

    logic               busyReg;
    logic               doneReg;
    logic               regWriteReg;
    logic               illegalReg;
    logic [WIDTH-1:0]   resultReg;
    logic [RD_W-1:0]    rdOutReg;
    logic               carryReg;
    logic               zeroReg;
    logic               signReg;

    logic [WIDTH:0]     combOut;
    logic [SHAMT_W-1:0] amount;
    logic               reqShift;
    logic [WIDTH-1:0]   idleValue;
    logic               idleCarry;
    logic [WIDTH-1:0]   shiftNext;
    logic               shiftOut;

    // The one-cycle ops are evaluated straight off the request so the result
    // can be registered on the same edge that accepts start.
    alu_comb #(.WIDTH(WIDTH)) uAluComb (
        .aluOp (bus.aluOp),
        .a     (bus.opA),
        .b     (bus.opB),
        .out   (combOut)
    );

    assign amount   = bus.opB[SHAMT_W-1:0];
    assign reqShift = isShiftOp(bus.aluOp);

    // A shift by zero completes immediately with opA unchanged and carry 0.
    always_comb begin
        idleValue = combOut[WIDTH-1:0];
        idleCarry = combOut[WIDTH];
        if (reqShift) begin
            idleValue = bus.opA;
            idleCarry = 1'b0;
        end
    end

    // One step of the shifter; shiftOut is the bit leaving the register.
    always_comb begin
        shiftNext = work;
        shiftOut  = 1'b0;
        case (opReg)
            ALU_SHLL: begin
                shiftNext = {work[WIDTH-2:0], 1'b0};
                shiftOut  = work[WIDTH-1];
            end
            ALU_SHRL: begin
                shiftNext = {1'b0, work[WIDTH-1:1]};
                shiftOut  = work[0];
            end
            ALU_SHRA: begin
                shiftNext = {work[WIDTH-1], work[WIDTH-1:1]};
                shiftOut  = work[0];
            end
            default: begin
                shiftNext = work;
                shiftOut  = 1'b0;
            end
        endcase
    end

    // Control FSM. done/regWrite/illegalOp are raised on the edge that enters
    // DONE and dropped on the edge that leaves it, so they are one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            opReg       <= ALU_ADD;
            work        <= '0;
            count       <= '0;
            rdReg       <= '0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
            regWriteReg <= 1'b0;
            illegalReg  <= 1'b0;
            resultReg   <= '0;
            rdOutReg    <= '0;
            carryReg    <= 1'b0;
            zeroReg     <= 1'b0;
            signReg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    doneReg     <= 1'b0;
                    regWriteReg <= 1'b0;
                    illegalReg  <= 1'b0;
                    if (bus.start) begin
                        opReg <= alu_op_e'(bus.aluOp);
                        rdReg <= bus.rdIn;
                        work  <= bus.opA;
                        count <= amount;
                        if (reqShift && (amount != '0)) begin
                            state   <= SHIFT;
                            busyReg <= 1'b1;
                        end else begin
                            state   <= DONE;
                            doneReg <= 1'b1;
                            if (bus.aluOp == ALU_ILLEGAL) begin
                                illegalReg <= 1'b1;
                            end else begin
                                regWriteReg <= 1'b1;
                                resultReg   <= idleValue;
                                carryReg    <= idleCarry;
                                zeroReg     <= (idleValue == '0);
                                signReg     <= idleValue[WIDTH-1];
                                rdOutReg    <= bus.rdIn;
                            end
                        end
                    end
                end

                SHIFT: begin
                    work  <= shiftNext;
                    count <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) begin
                        state       <= DONE;
                        busyReg     <= 1'b0;
                        doneReg     <= 1'b1;
                        regWriteReg <= 1'b1;
                        resultReg   <= shiftNext;
                        carryReg    <= shiftOut;
                        zeroReg     <= (shiftNext == '0);
                        signReg     <= shiftNext[WIDTH-1];
                        rdOutReg    <= rdReg;
                    end
                end

                DONE: begin
                    state       <= IDLE;
                    doneReg     <= 1'b0;
                    regWriteReg <= 1'b0;
                    illegalReg  <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                    doneReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busyReg;
    assign bus.done      = doneReg;
    assign bus.regWrite  = regWriteReg;
    assign bus.illegalOp = illegalReg;
    assign bus.result    = resultReg;
    assign bus.rdOut     = rdOutReg;
    assign bus.carry     = carryReg;
    assign bus.zero      = zeroReg;
    assign bus.sign      = signReg;

endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu
// Self-checking bench for iterative_alu. Requests are issued by a driver that
// pushes the expected completion into a scoreboard queue; a monitor pops and
// compares whenever done is seen. Expected values come from a plain-arithmetic
// reference model of the opcode rules.
module tb_iterative_alu;
    import kgp_risc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    iterative_alu_if #(.WIDTH(32)) bus ();

    iterative_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        carry;
        logic        zero;
        logic        sign;
        logic        illegal;
        logic        regWrite;
    } exp_t;

    exp_t expQ[$];
    int   errors    = 0;
    int   checks    = 0;
    int   doneCount = 0;

    // Architectural view of the last completed legal operation.
    logic [31:0] mResult = '0;
    logic [4:0]  mRd     = '0;
    logic        mCarry  = 1'b0;
    logic        mZero   = 1'b0;
    logic        mSign   = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic resetModel();
        mResult = '0;
        mRd     = '0;
        mCarry  = 1'b0;
        mZero   = 1'b0;
        mSign   = 1'b0;
        expQ.delete();
    endtask

    // Reference model: result and carry straight from the opcode definitions.
    task automatic predict(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
        exp_t        e;
        int          k;
        logic [32:0] sum;
        logic [31:0] r;
        logic        c;
        k = int'(b[4:0]);
        c = 1'b0;
        r = mResult;
        case (op)
            3'd0: begin sum = {1'b0, a} + {1'b0, b}; r = sum[31:0]; c = sum[32]; end
            3'd1: r = 32'd0 - b;
            3'd2: r = a & b;
            3'd3: r = a ^ b;
            3'd4: begin r = a << k; if (k > 0) c = a[32 - k]; end
            3'd5: begin r = a >> k; if (k > 0) c = a[k - 1]; end
            3'd6: begin r = 32'($signed(a) >>> k); if (k > 0) c = a[k - 1]; end
            default: r = mResult;
        endcase
        if (op == 3'd7) begin
            e.result = mResult; e.rd = mRd; e.carry = mCarry;
            e.zero = mZero; e.sign = mSign; e.illegal = 1'b1; e.regWrite = 1'b0;
        end else begin
            mResult = r; mRd = rd; mCarry = c; mZero = (r == 32'd0); mSign = r[31];
            e.result = r; e.rd = rd; e.carry = c;
            e.zero = mZero; e.sign = mSign; e.illegal = 1'b0; e.regWrite = 1'b1;
        end
        expQ.push_back(e);
    endtask

    // Issue one request and wait (bounded) for its completion, checking the
    // done latency and the number of busy cycles. With holdStart the start
    // line stays high with different operands until done is seen.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input bit holdStart);
        int  expLat;
        int  lat;
        int  busyCycles;
        bit  seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluOp = op;
        bus.opA   = a;
        bus.opB   = b;
        bus.rdIn  = rd;
        predict(op, a, b, rd);
        expLat = ((op >= 3'd4) && (op <= 3'd6) && (b[4:0] != 5'd0)) ? int'(b[4:0]) + 1 : 1;
        @(posedge clk);
        #1;
        if (holdStart) begin
            bus.opA  = ~a;
            bus.opB  = b + 32'd1;
            bus.rdIn = rd + 5'd1;
        end else begin
            bus.start = 1'b0;
        end
        lat        = 0;
        busyCycles = 0;
        seen       = 1'b0;
        while (!seen && lat < 64) begin
            @(negedge clk);
            lat++;
            if (bus.done === 1'b1) seen = 1'b1;
            else if (bus.busy === 1'b1) busyCycles++;
        end
        bus.start = 1'b0;
        checkOutput($sformatf("latency op=%0d amt=%0d", op, b[4:0]), 64'(lat), 64'(expLat));
        checkOutput($sformatf("busyCycles op=%0d", op), 64'(busyCycles), 64'(expLat - 1));
        repeat (2) @(posedge clk);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before the next edge.
    task automatic asyncReset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput({tag, " result"},   64'(bus.result),    64'd0);
        checkOutput({tag, " rdOut"},    64'(bus.rdOut),     64'd0);
        checkOutput({tag, " flags"},    64'({bus.carry, bus.zero, bus.sign}), 64'd0);
        checkOutput({tag, " strobes"},  64'({bus.done, bus.regWrite, bus.illegalOp, bus.busy}), 64'd0);
        checkOutput({tag, " state"},    64'(dut.state),     64'(IDLE));
        resetModel();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every done is matched against the oldest expected completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected done: actual=1 required=0 at %0t", $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("result",    64'(bus.result),    64'(e.result));
                    checkOutput("rdOut",     64'(bus.rdOut),     64'(e.rd));
                    checkOutput("carry",     64'(bus.carry),     64'(e.carry));
                    checkOutput("zero",      64'(bus.zero),      64'(e.zero));
                    checkOutput("sign",      64'(bus.sign),      64'(e.sign));
                    checkOutput("illegalOp", 64'(bus.illegalOp), 64'(e.illegal));
                    checkOutput("regWrite",  64'(bus.regWrite),  64'(e.regWrite));
                end
            end else if (rst === 1'b0 && (bus.regWrite !== 1'b0 || bus.illegalOp !== 1'b0)) begin
                checks++;
                errors++;
                $display("[TB] FAIL strobe without done: actual=%0b%0b required=00 at %0t",
                         bus.regWrite, bus.illegalOp, $time);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          donesBefore;

        bus.start = 1'b0;
        bus.aluOp = 3'd0;
        bus.opA   = '0;
        bus.opB   = '0;
        bus.rdIn  = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("post-reset outputs", 64'({bus.result, bus.rdOut, bus.carry, bus.zero, bus.sign}), 64'd0);
        checkOutput("post-reset strobes", 64'({bus.done, bus.regWrite, bus.illegalOp, bus.busy}), 64'd0);

        // ADD wrapping to zero with carry out.
        applyStimulus(3'd0, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b0);
        asyncReset("midcycle reset");

        // SHRA of the sign bit by 4.
        applyStimulus(3'd6, 32'h8000_0000, 32'd4, 5'd3, 1'b0);
        // SHLL with a zero amount field (upper opB bits ignored).
        applyStimulus(3'd4, 32'h1234_5678, 32'h20, 5'd9, 1'b0);
        // SHRL by 3 with start held high and changing operands.
        applyStimulus(3'd5, 32'hF0F0_1234, 32'd3, 5'd12, 1'b1);
        // Illegal opcode leaves result/rdOut/flags untouched.
        applyStimulus(3'd7, 32'hDEAD_BEEF, 32'h1, 5'd30, 1'b0);
        // COMP boundaries and full-width shifts.
        applyStimulus(3'd1, 32'h5555_5555, 32'd0, 5'd1, 1'b0);
        applyStimulus(3'd1, 32'd0, 32'd1, 5'd2, 1'b0);
        applyStimulus(3'd4, 32'h0000_0003, 32'd31, 5'd4, 1'b0);
        applyStimulus(3'd6, 32'h4000_0001, 32'd31, 5'd5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) b[4:0] = 5'd0;
            if ($urandom_range(0, 9) == 0) b = 32'd0;
            applyStimulus(op, a, b, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a SHRL by 10: no completion may follow.
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluOp = 3'd5;
        bus.opA   = 32'hABCD_0000;
        bus.opB   = 32'd10;
        bus.rdIn  = 5'd17;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        donesBefore = doneCount;
        asyncReset("abort reset");
        repeat (15) @(negedge clk);
        checkOutput("dones after abort", 64'(doneCount - donesBefore), 64'd0);
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
